// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : RV32I instruction fetch: PC register, next-PC select, IF/ID register
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        pred_jump,
    input  logic [31:0] pred_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
);

    // Only word-aligned fetch is possible, so the low two bits are never stored.
    logic [29:0] pc_word;

    assign irom_addr = {pc_word, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_word   <= RESET_PC[31:2];
            id_pc     <= 32'd0;
            id_pc4    <= 32'd0;
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
            fetch_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (redirect) begin
            pc_word   <= redirect_pc[31:2];
            id_pc     <= 32'd0;
            id_pc4    <= 32'd0;
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
            flush_cnt <= flush_cnt + 32'd1;
        end else if (!stall) begin
            if (pred_jump && id_valid) begin
                // Squash the sequential fetch that followed the jump.
                pc_word   <= pred_pc[31:2];
                id_pc     <= 32'd0;
                id_pc4    <= 32'd0;
                id_inst   <= NOP_INST;
                id_valid  <= 1'b0;
                flush_cnt <= flush_cnt + 32'd1;
            end else begin
                pc_word   <= pc_word + 30'd1;
                id_pc     <= irom_addr;
                id_pc4    <= irom_addr + 32'd4;
                id_inst   <= irom_inst;
                id_valid  <= 1'b1;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : scoreboard bench for if_fetch_stage against a cycle reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        pred_jump = 1'b0;
    logic [31:0] pred_pc = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] irom_addr;
    logic [31:0] irom_inst;
    logic [31:0] id_pc, id_pc4, id_inst, fetch_cnt, flush_cnt;
    logic        id_valid;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] fcnt;
        logic [31:0] xcnt;
    } exp_t;

    exp_t sb[$];

    // Reference state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc, m_id_pc, m_id_pc4, m_inst, m_fcnt, m_xcnt;
    logic        m_valid;

    if_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .pred_jump(pred_jump),
        .pred_pc(pred_pc), .redirect(redirect), .redirect_pc(redirect_pc),
        .irom_addr(irom_addr), .irom_inst(irom_inst), .id_pc(id_pc),
        .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid),
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h0000_0013;
    endfunction

    assign irom_inst = rom(irom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_inst = NOP;
        m_valid = 1'b0; m_fcnt = 32'h0; m_xcnt = 32'h0;
    endtask

    task automatic model_flush(input logic [31:0] target);
        m_pc = {target[31:2], 2'b00};
        m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_inst = NOP; m_valid = 1'b0;
        m_xcnt = m_xcnt + 1;
    endtask

    // Called at a falling edge: drive one cycle, predict the result of the next rising edge.
    task automatic cycle(input logic s, input logic pj, input logic [31:0] ppc,
                         input logic rd, input logic [31:0] rpc);
        exp_t e;
        stall = s; pred_jump = pj; pred_pc = ppc; redirect = rd; redirect_pc = rpc;
        if (rd) model_flush(rpc);
        else if (!s) begin
            if (pj && m_valid) model_flush(ppc);
            else begin
                m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_inst = rom(m_pc);
                m_valid = 1'b1; m_pc = m_pc + 4; m_fcnt = m_fcnt + 1;
            end
        end
        e = '{addr: m_pc, pc: m_id_pc, pc4: m_id_pc4, inst: m_inst,
              valid: m_valid, fcnt: m_fcnt, xcnt: m_xcnt};
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, irom_addr, 32'h0);
        chk({tag, "_id_pc"}, id_pc, 32'h0);
        chk({tag, "_id_pc4"}, id_pc4, 32'h0);
        chk({tag, "_id_inst"}, id_inst, NOP);
        chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'h0);
        chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
        chk({tag, "_flush_cnt"}, flush_cnt, 32'h0);
    endtask

    // Monitor: every rising edge with a pending prediction is checked 2ns later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("irom_addr", irom_addr, e.addr);
                chk("id_pc", id_pc, e.pc);
                chk("id_pc4", id_pc4, e.pc4);
                chk("id_inst", id_inst, e.inst);
                chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
                chk("fetch_cnt", fetch_cnt, e.fcnt);
                chk("flush_cnt", flush_cnt, e.xcnt);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 chk_reset_vals("por");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch
        plain(10);
        chk("ten_fetches", fetch_cnt, 32'd10);
        chk("no_flushes", flush_cnt, 32'd0);

        // Predicted jump lands in ID-valid slot; pred_jump also tested while invalid
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
        plain(3);

        // Redirect beats stall and pred_jump together
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100);
        plain(8);

        // Stall with a pred_jump pulse in the middle
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        plain(2);

        // Misaligned redirect target, then PC wrap at the top of the address space
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103);
        plain(2);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        plain(4);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        plain(3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3) == 0), ($urandom_range(3) == 0), $urandom,
                  ($urandom_range(7) == 0), $urandom);
        end

        // Asynchronous reset between edges during a redirect
        redirect = 1'b1; redirect_pc = 32'h0000_0500; stall = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        model_reset();
        @(negedge clk);
        chk_reset_vals("held");
        redirect = 1'b0; stall = 1'b0;
        rst_n = 1'b1;
        plain(6);
        for (int i = 0; i < 100; i++) begin
            cycle(($urandom_range(3) == 0), ($urandom_range(2) == 0), $urandom_range(255) << 2,
                  ($urandom_range(9) == 0), $urandom);
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
